// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional CPU lock feature is controlled by macro DMEM_ARB_LOCK_EN.
package dmem_arb_pkg;

  // Access sequencer state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Requester identifiers; also used as the round-robin history
  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } gnt_t;

  // Width of the access-cycle down-counter (MEM_LAT up to 15)
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
// req[0] is the CPU, req[1] is the debug port. 'lock' forces the CPU
// to win whenever it is requesting; otherwise a tie goes to whoever
// was not granted last.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_t       last,
  input  logic       lock,
  output logic       gnt_valid,
  output gnt_t       gnt_id
);

  // Pick the winner among the active requests
  always_comb begin
    gnt_valid = |req;
    gnt_id    = GNT_CPU;
    if (lock && req[0]) begin
      gnt_id = GNT_CPU;
    end else if (req[0] && req[1]) begin
      gnt_id = (last == GNT_CPU) ? GNT_DBG : GNT_CPU;
    end else if (req[1]) begin
      gnt_id = GNT_DBG;
    end else begin
      gnt_id = GNT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares a single-port DMEM between the CPU
// load/store path and a debug/loader port. Round-robin arbitration in
// IDLE, fixed MEM_LAT-cycle access in BUSY, one-cycle ready pulse to
// the owner in the final access cycle.
// Handshake: a requester holds req (and its we/addr/wdata) until it
// sees ready for one cycle; the request fields are sampled only at the
// grant edge, and a req still high in the following IDLE cycle is a new
// request.
// Optional: define DMEM_ARB_LOCK_EN to add cpu_lock, which keeps the
// CPU granted across consecutive accesses for read-modify-write.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              cpu_lock,
`endif
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            fsm_state_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic             LAT_ONE  = (MEM_LAT == 1);

  state_t            state_q;
  gnt_t              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              cpu_ready_q;
  logic              dbg_ready_q;

  logic              gnt_valid;
  gnt_t              gnt_id;
  logic              lock_eff;

  logic              req_we_d;
  logic [ADDR_W-1:0] req_addr_d;
  logic [DATA_W-1:0] req_wdata_d;
  logic              ready_set_d;
  gnt_t              ready_owner_d;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q;

  // Lock follows cpu_lock at each CPU completion; drops when the CPU goes quiet
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_q <= 1'b0;
    end else if (state_q == ST_BUSY && cnt_q == '0 && last_q == GNT_CPU) begin
      lock_q <= cpu_lock;
    end else if (state_q == ST_IDLE && !cpu_req) begin
      lock_q <= 1'b0;
    end
  end

  assign lock_eff = lock_q;
`else
  assign lock_eff = 1'b0;
`endif

  rr_pick2 u_pick (
    .req       ({dbg_req, cpu_req}),
    .last      (last_q),
    .lock      (lock_eff),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Winner's request fields, and whether the next cycle is a final access cycle
  always_comb begin
    req_we_d      = (gnt_id == GNT_CPU) ? cpu_we    : dbg_we;
    req_addr_d    = (gnt_id == GNT_CPU) ? cpu_addr  : dbg_addr;
    req_wdata_d   = (gnt_id == GNT_CPU) ? cpu_wdata : dbg_wdata;
    ready_set_d   = 1'b0;
    ready_owner_d = last_q;
    if (state_q == ST_IDLE) begin
      ready_set_d   = gnt_valid && LAT_ONE;
      ready_owner_d = gnt_id;
    end else if (cnt_q == CNT_W'(1)) begin
      ready_set_d   = 1'b1;
      ready_owner_d = last_q;
    end
  end

  // Arbitration / access sequencer with registered memory-side outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      last_q      <= GNT_DBG;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
    end else begin
      cpu_ready_q <= ready_set_d && (ready_owner_d == GNT_CPU);
      dbg_ready_q <= ready_set_d && (ready_owner_d == GNT_DBG);
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            state_q     <= ST_BUSY;
            mem_en_q    <= 1'b1;
            mem_we_q    <= req_we_d;
            mem_addr_q  <= req_addr_d;
            mem_wdata_q <= req_wdata_d;
            cnt_q       <= CNT_INIT;
            last_q      <= gnt_id;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            state_q  <= ST_IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (!mem_we_q) begin
              if (last_q == GNT_CPU) cpu_rdata_q <= mem_rdata;
              else                   dbg_rdata_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read data is only valid from DMEM in the final cycle, so pass it through then
  assign cpu_rdata   = (cpu_ready_q && !mem_we_q) ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata   = (dbg_ready_q && !mem_we_q) ? mem_rdata : dbg_rdata_q;
  assign cpu_ready   = cpu_ready_q;
  assign dbg_ready   = dbg_ready_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign fsm_state_o = state_q;

endmodule
